// File: rtl/beat_generator.sv
`default_nettype none
// ============================================================================
//  Module      : beat_generator
//  Description : Tempo source. Divides the system clock into one-cycle beat
//                strobes at one of four tempos, with a mid-beat half_beat
//                strobe, a running beat index and pause/resume support.
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_generator #(
    parameter int DIV0   = 12_000_000,
    parameter int DIV1   = 8_000_000,
    parameter int DIV2   = 6_000_000,
    parameter int DIV3   = 4_800_000,
    parameter int CNT_W  = 24,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        tempo_sel,
    input  logic              finish,
    output logic              beat_clk,
    output logic              half_beat,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              running
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [CNT_W-1:0]  c_DIV0    = CNT_W'(DIV0);
    localparam logic [CNT_W-1:0]  c_DIV1    = CNT_W'(DIV1);
    localparam logic [CNT_W-1:0]  c_DIV2    = CNT_W'(DIV2);
    localparam logic [CNT_W-1:0]  c_DIV3    = CNT_W'(DIV3);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [BEAT_W-1:0] c_IDX_ONE = BEAT_W'(1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_presc;
    logic [CNT_W-1:0]  r_div_q;
    logic [BEAT_W-1:0] r_beat_idx;
    logic              r_beat_clk;
    logic              r_half_beat;
    logic [CNT_W-1:0]  w_sel_div;
    logic              w_wrap;
    logic              w_mid;

    // Period selected by tempo_sel; only consumed when a start is accepted.
    always_comb begin
        w_sel_div = c_DIV0;
        case (tempo_sel)
            2'd1:    w_sel_div = c_DIV1;
            2'd2:    w_sel_div = c_DIV2;
            2'd3:    w_sel_div = c_DIV3;
            default: w_sel_div = c_DIV0;
        endcase
    end

    // Last prescaler count of a beat, and the count that precedes mid-beat.
    assign w_wrap = (r_presc == (r_div_q - c_CNT_ONE));
    assign w_mid  = (r_presc == ((r_div_q >> 1) - c_CNT_ONE));

    // Song state, prescaler and strobes. A counting edge happens in RUN or
    // PAUSE whenever pause is low and finish is not asserted, so the edge that
    // resumes from PAUSE already advances the prescaler: each pause-high cycle
    // delays the next beat by exactly one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_IDLE;
            r_presc     <= '0;
            r_div_q     <= c_DIV0;
            r_beat_idx  <= '0;
            r_beat_clk  <= 1'b0;
            r_half_beat <= 1'b0;
        end else begin
            r_beat_clk  <= 1'b0;
            r_half_beat <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state    <= c_RUN;
                        r_presc    <= '0;
                        r_beat_idx <= '0;
                        r_div_q    <= w_sel_div;
                    end
                end
                c_RUN, c_PAUSE: begin
                    if (finish) begin
                        r_state <= c_DONE;
                    end else if (pause) begin
                        r_state <= c_PAUSE;
                    end else begin
                        r_state <= c_RUN;
                        if (w_wrap) begin
                            r_presc    <= '0;
                            r_beat_clk <= 1'b1;
                            r_beat_idx <= r_beat_idx + c_IDX_ONE;
                        end else begin
                            r_presc <= r_presc + c_CNT_ONE;
                        end
                        if (w_mid) begin
                            r_half_beat <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign beat_clk  = r_beat_clk;
    assign half_beat = r_half_beat;
    assign beat_idx  = r_beat_idx;
    assign running   = (r_state == c_RUN) || (r_state == c_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_beat_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beat_generator
//  Description : Randomised scoreboard bench for beat_generator with a
//                tick-counting reference model of the song timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_generator;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        bit is_beat;
        int edge_n;
    } ev_t;

    logic       tb_clk = 1'b0;
    logic       n_rst  = 1'b0;
    logic       start  = 1'b0;
    logic       pause  = 1'b0;
    logic [1:0] tempo_sel = 2'd0;
    logic       finish = 1'b0;
    logic       beat_clk;
    logic       half_beat;
    logic [7:0] beat_idx;
    logic       running;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    ev_t  sb[$];

    // reference model: song mode, RUN ticks since start, beat period, beats
    int   m_mode   = M_IDLE;
    int   m_ticks  = 0;
    int   m_period = 8;
    int   m_beats  = 0;
    bit   m_last_beat = 1'b0;

    beat_generator #(
        .DIV0(8), .DIV1(6), .DIV2(4), .DIV3(12), .CNT_W(24), .BEAT_W(8)
    ) dut (
        .clk(tb_clk), .n_rst(n_rst), .start(start), .pause(pause),
        .tempo_sel(tempo_sel), .finish(finish), .beat_clk(beat_clk),
        .half_beat(half_beat), .beat_idx(beat_idx), .running(running)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int div_of(input int sel);
        case (sel)
            1:       return 6;
            2:       return 4;
            3:       return 12;
            default: return 8;
        endcase
    endfunction

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_ticks = 0;
        m_beats = 0;
        m_last_beat = 1'b0;
        sb.delete();
    endfunction

    // Effect of the coming clock edge (number cyc+1) given the inputs.
    function automatic void model_edge(input bit s, input bit p, input int sel, input bit f);
        ev_t e;
        m_last_beat = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (s) begin
                m_mode   = M_RUN;
                m_ticks  = 0;
                m_beats  = 0;
                m_period = div_of(sel);
            end
        end else begin
            if (f) begin
                m_mode = M_DONE;
            end else if (p) begin
                m_mode = M_PAUSE;
            end else begin
                m_mode = M_RUN;
                m_ticks++;
                e.edge_n = cyc + 1;
                if (m_ticks % m_period == 0) begin
                    m_beats++;
                    e.is_beat = 1'b1;
                    sb.push_back(e);
                    m_last_beat = 1'b1;
                end else if (m_ticks % m_period == m_period / 2) begin
                    e.is_beat = 1'b0;
                    sb.push_back(e);
                end
            end
        end
    endfunction

    task automatic step(input bit s, input bit p, input int sel, input bit f);
        @(negedge tb_clk);
        start     = s;
        pause     = p;
        tempo_sel = 2'(sel);
        finish    = f;
        model_edge(s, p, sel, f);
    endtask

    // Monitor: per-cycle state comparison and strobe scoreboard.
    always @(posedge tb_clk) begin
        ev_t e;
        cyc++;
        #1;
        if (n_rst) begin
            chk("running", int'(running), int'(m_mode == M_RUN || m_mode == M_PAUSE));
            chk("beat_idx", int'(beat_idx), m_beats % 256);
            while (sb.size() > 0 && sb[0].edge_n < cyc) begin
                e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_strobe: got none expected %s at edge %0d",
                         e.is_beat ? "beat_clk" : "half_beat", e.edge_n);
            end
            if (beat_clk || half_beat) begin
                chk("strobe_overlap", int'(beat_clk && half_beat), 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got beat_clk=%0d half_beat=%0d expected none",
                             beat_clk, half_beat);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_edge", cyc, e.edge_n);
                    chk("strobe_kind_beat", int'(beat_clk), int'(e.is_beat));
                end
            end
        end
    end

    initial begin
        int pl;
        // reset state
        repeat (2) @(posedge tb_clk);
        #2;
        chk("rst_beat_clk", int'(beat_clk), 0);
        chk("rst_half_beat", int'(half_beat), 0);
        chk("rst_beat_idx", int'(beat_idx), 0);
        chk("rst_running", int'(running), 0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        model_reset();

        // start at tempo 0, finish on the wrap edge of beat 3
        step(1, 0, 0, 0);
        repeat (23) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        #6;
        chk("done_beat_idx", int'(beat_idx), 2);
        chk("done_running", int'(running), 0);

        // restart, then pause 5 cycles at prescaler 3
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (5) step(0, 1, 2, 0);
        repeat (20) step(0, 0, 3, 0);

        // start ignored while running; pause+start together from DONE
        step(1, 0, 1, 0);
        step(0, 0, 0, 1);
        step(1, 1, 1, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (15) step(0, 0, 2, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // tempo 2, tempo_sel wandering; run past a beat_idx wrap
        step(1, 0, 2, 0);
        repeat (260 * 4 + 3) step(0, 0, $urandom_range(0, 3), 0);

        // async reset while beat_clk is high
        for (int i = 0; i < 20 && !m_last_beat; i++) step(0, 0, 0, 0);
        @(posedge tb_clk);
        #2;
        n_rst = 1'b0;
        start = 1'b0; pause = 1'b0; finish = 1'b0;
        #1;
        chk("arst_beat_clk", int'(beat_clk), 0);
        chk("arst_half_beat", int'(half_beat), 0);
        chk("arst_beat_idx", int'(beat_idx), 0);
        chk("arst_running", int'(running), 0);
        model_reset();
        @(negedge tb_clk);
        n_rst = 1'b1;
        repeat (10) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 3, 0);
        repeat (30) step(0, 0, 0, 0);

        // random song control
        pl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) pl = 1 - pl;
            step(($urandom_range(0, 24) == 0), pl[0], $urandom_range(0, 3),
                 ($urandom_range(0, 149) == 0));
        end

        repeat (3) step(0, 0, 0, 0);
        @(posedge tb_clk);
        #3;
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
